// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one combinational logical unit among NREQ requesters.
// Results return through a single registered response slot that supports backpressure.

module logical_unit #(
    parameter int N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [1:0]   af_i,
    input  logic         imm_i,
    output logic [N-1:0] res_o
);
    always_comb begin
        res_o = '0;
        if (imm_i) begin
            res_o = {b_i[15:0], {(N-16){1'b0}}};
        end else begin
            case (af_i)
                2'b00:   res_o = a_i & b_i;
                2'b01:   res_o = a_i | b_i;
                2'b10:   res_o = a_i ^ b_i;
                default: res_o = ~(a_i | b_i);
            endcase
        end
    end
endmodule

module logic_unit_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ*2-1:0] req_af,
    input  logic [NREQ-1:0]   req_i,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_res,
    output logic [7:0]        busy_cnt
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] win, idx;
    logic           found, can_accept, accept;
    logic [N-1:0]   sel_a, sel_b, lu_res;
    logic [1:0]     sel_af;
    logic           sel_i;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [N-1:0]   rsp_res_q, rsp_res_d;
    logic [7:0]     busy_q, busy_d;

    // Priority search starts at the round-robin pointer and wraps.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign can_accept = !rsp_valid_q || rsp_ready;
    // Gated by rst_n so no grant is offered while reset is held.
    assign accept     = rst_n && found && can_accept;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_af = '0;
        sel_i  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == IDW'(k)) begin
                sel_a  = req_a[k*N +: N];
                sel_b  = req_b[k*N +: N];
                sel_af = req_af[k*2 +: 2];
                sel_i  = req_i[k];
            end
        end
    end

    logical_unit #(.N(N)) u_lu (
        .a_i   (sel_a),
        .b_i   (sel_b),
        .af_i  (sel_af),
        .imm_i (sel_i),
        .res_o (lu_res)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        busy_d      = busy_q;
        if (accept) begin
            ptr_d       = (int'(win) == NREQ-1) ? '0 : win + IDW'(1);
            rsp_valid_d = 1'b1;
            rsp_id_d    = win;
            rsp_res_d   = lu_res;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if ((|req_valid) && !accept && (busy_q != 8'hFF)) busy_d = busy_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
            busy_q      <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign busy_cnt  = busy_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a reference grant model and a response scoreboard.

module tb_logic_unit_arbiter;
    localparam logic [31:0] OPA = 32'hAAAA5555;
    localparam logic [31:0] OPB = 32'h99996666;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_ready, req_i;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_af;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_res;
    logic [7:0]   busy_cnt;

    int   vectors = 0;
    int   miscompares = 0;
    rsp_t sb[$];
    int   grants[$];
    int   ptr_m = 0;
    int   busy_m = 0;
    int   b0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.N(32), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_af    (req_af),
        .req_i     (req_i),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .busy_cnt  (busy_cnt)
    );

    function automatic logic [31:0] lu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] af, input logic imm);
        if (imm) return {b[15:0], 16'h0000};
        case (af)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [1:0] af, input logic imm);
        req_a[k*32 +: 32] = OPA;
        req_b[k*32 +: 32] = OPB;
        req_af[k*2 +: 2]  = af;
        req_i[k]          = imm;
    endtask

    // Mid-cycle model: check the current outputs, then predict the next edge.
    always @(negedge clk) begin
        logic       have;
        logic [3:0] exp_g;
        int         w;
        rsp_t       e;
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
        end else begin
            have = sb.size() > 0;
            chk("rsp_valid", 64'(rsp_valid), 64'(have));
            if (have) begin
                chk("sb_rsp_id", 64'(rsp_id), 64'(sb[0].id));
                chk("sb_rsp_res", 64'(rsp_res), 64'(sb[0].res));
            end
            chk("busy_cnt", 64'(busy_cnt), 64'(busy_m));
            exp_g = '0;
            w = -1;
            if (!have || rsp_ready) begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (ptr_m + k) % 4;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
            if (w >= 0) exp_g[w] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(exp_g));
            chk("one_hot", 64'($countones(req_ready) <= 1), 64'd1);
            if (have && rsp_ready) void'(sb.pop_front());
            if (w >= 0) begin
                e.id  = 2'(w);
                e.res = lu_model(req_a[w*32 +: 32], req_b[w*32 +: 32], req_af[w*2 +: 2], req_i[w]);
                sb.push_back(e);
                grants.push_back(w);
                ptr_m = (w + 1) % 4;
            end
            if (req_valid != 4'd0 && w < 0 && busy_m < 255) busy_m++;
        end
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a = '0;
        req_b = '0;
        req_af = '0;
        req_i = '0;
        for (int k = 0; k < 4; k++) set_req(k, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0001;
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_res", 64'(rsp_res), 64'd0);
        chk("reset_busy_cnt", 64'(busy_cnt), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);

        // T1: back-to-back AND, OR, XOR, NOR from requester 0
        set_req(0, 2'b00, 1'b0); req_valid = 4'b0001; cyc(1);
        chk("t1_and", 64'(rsp_res), 64'h88884444);
        chk("t1_id", 64'(rsp_id), 64'd0);
        set_req(0, 2'b01, 1'b0); cyc(1);
        chk("t1_or", 64'(rsp_res), 64'hBBBB7777);
        set_req(0, 2'b10, 1'b0); cyc(1);
        chk("t1_xor", 64'(rsp_res), 64'h33333333);
        set_req(0, 2'b11, 1'b0); cyc(1);
        chk("t1_nor", 64'(rsp_res), 64'h44448888);
        chk("t1_valid", 64'(rsp_valid), 64'd1);
        req_valid = '0; cyc(1);
        chk("t1_retire", 64'(rsp_valid), 64'd0);

        // T2: immediate mode from requester 2
        set_req(2, 2'b11, 1'b1); req_valid = 4'b0100; cyc(1);
        chk("t2_res", 64'(rsp_res), 64'h66660000);
        chk("t2_id", 64'(rsp_id), 64'd2);
        req_valid = '0; set_req(2, 2'b00, 1'b0); cyc(1);
        set_req(3, 2'b00, 1'b0); req_valid = 4'b1000; cyc(1);
        req_valid = '0; cyc(1);

        // T3: fairness with all requesters valid
        for (int k = 0; k < 4; k++) set_req(k, 2'(k), 1'b0);
        grants.delete();
        req_valid = 4'hF; cyc(8);
        req_valid = '0;
        chk("t3_grant_count", 64'(grants.size()), 64'd8);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("t3_order", 64'(grants[k]), 64'(k % 4));
        cyc(2);

        // T4: backpressure for 3 cycles with requester 1 waiting
        set_req(0, 2'b00, 1'b0); set_req(1, 2'b01, 1'b0);
        rsp_ready = 1'b1; req_valid = 4'b0001; cyc(1);
        rsp_ready = 1'b0; req_valid = 4'b0010; #1;
        b0 = busy_m;
        chk("t4_blocked", 64'(req_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("t4_hold_res", 64'(rsp_res), 64'h88884444);
            chk("t4_hold_id", 64'(rsp_id), 64'd0);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
        end
        chk("t4_busy_delta", 64'(busy_cnt), 64'(b0 + 3));
        rsp_ready = 1'b1; #1;
        chk("t4_release_ready", 64'(req_ready), 64'b0010);
        cyc(1);
        chk("t4_no_bubble", 64'(rsp_valid), 64'd1);
        chk("t4_id", 64'(rsp_id), 64'd1);
        chk("t4_res", 64'(rsp_res), 64'hBBBB7777);
        req_valid = '0; cyc(2);

        // T5: busy counter saturation
        req_valid = 4'b0001; cyc(1);
        rsp_ready = 1'b0; req_valid = 4'b0010; cyc(300);
        chk("t5_sat", 64'(busy_cnt), 64'd255);
        cyc(5);
        chk("t5_sat_hold", 64'(busy_cnt), 64'd255);
        rsp_ready = 1'b1; cyc(1);
        req_valid = '0; cyc(2);

        // T6: asynchronous reset with a pending response
        req_valid = 4'b0001; cyc(1);
        rsp_ready = 1'b0; req_valid = '0;
        chk("t6_pending", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        sb.delete(); ptr_m = 0; busy_m = 0;
        #1;
        chk("t6_async_valid", 64'(rsp_valid), 64'd0);
        chk("t6_async_busy", 64'(busy_cnt), 64'd0);
        set_req(0, 2'b01, 1'b0); set_req(3, 2'b10, 1'b0);
        req_valid = 4'b1001; rsp_ready = 1'b1;
        cyc(2);
        rst_n = 1'b1; #1;
        chk("t6_first_grant", 64'(req_ready), 64'b0001);
        cyc(1);
        chk("t6_first_id", 64'(rsp_id), 64'd0);
        chk("t6_first_valid", 64'(rsp_valid), 64'd1);
        #1;
        chk("t6_second_grant", 64'(req_ready), 64'b1000);
        cyc(1);
        chk("t6_second_id", 64'(rsp_id), 64'd3);
        chk("t6_second_res", 64'(rsp_res), 64'h33333333);
        req_valid = '0; cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
